queue_rd_arbiter: RTL and testbench
===================================

# queue_rd_arbiter

Round-robin read scheduler for the four-queue read path: it decides which queue drives the shared read port and for how long. It produces the registered one-hot `rd_sel_o` consumed by the one-hot-to-index read-select decoder and the output mux. It also produces the per-cycle read strobe, gated by downstream backpressure. Each grant is a burst of up to `BURST` words, and the grant is released early if the granted queue empties.

## Interface
- `BURST`, default 4: maximum reads per grant; legal range 1..15.
- `CW`, default 4: burst counter width; must satisfy 2^CW > BURST.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_i`  in  4  bit i high means queue i is non-empty.
- `rd_ready_i`  in  1  downstream accepts one word this cycle.
- `rd_sel_o`  out  4  registered one-hot grant. All-zero when no queue is granted. Never more than one bit set.
- `grant_idx_o`  out  2  binary index of the set bit of `rd_sel_o`; 0 when `rd_sel_o` is zero (never X).
- `rd_en_o`  out  1  combinational read strobe: asserted when state is SERVE, `rd_ready_i` is high and `req_i[grant_idx_o]` is high.
- `busy_o`  out  1  high while in SERVE.

## Operation
- Registered state:
  - FSM state: {IDLE, SERVE}.
  - `last[1:0]`: index of the last queue served.
  - `cnt[CW-1:0]`: reads completed in the current burst.
- Reset values: state=IDLE, `last`=3 (so queue 0 has first priority), `cnt`=0, `rd_sel_o`=0, `grant_idx_o`=0, `busy_o`=0, `rd_en_o`=0.
- Arbitration rule:
  - Search order is `last+1`, `last+2`, `last+3`, `last+4` (mod 4).
  - The winner is the first index in that order with `req_i` high.
  - The previous winner is therefore lowest priority, but is regranted if it is the only requester.
- IDLE state:
  - If `req_i` is nonzero: register the winner into `rd_sel_o`, set `cnt`=0, go to SERVE.
  - Otherwise stay in IDLE with `rd_sel_o`=0.
- SERVE state, with g = `grant_idx_o`:
  - Each cycle with `rd_en_o`=1: `cnt` increments by 1.
  - Burst complete: if `rd_en_o`=1 and `cnt`==BURST-1, release the grant.
  - Queue empty: if `req_i[g]`=0, release the grant, whether or not `cnt` has reached BURST.
  - `rd_ready_i`=0 holds the grant indefinitely. `cnt` does not advance and there is no timeout.
- Release action, taken at the clock edge: `last`=g, `rd_sel_o`=0, `cnt`=0, state goes to IDLE.
- The IDLE cycle after every release is a mandatory one-cycle re-arbitration bubble. It guarantees that `req_i` has reflected the final read before the next decision.
- Changes on `req_i` bits other than g have no effect during SERVE.
- Reset mid-burst:
  - `rd_sel_o`, `busy_o` and `rd_en_o` go to 0 immediately, asynchronously.
  - The partial burst is abandoned.
  - After reset is released, arbitration restarts from queue 0.

## Timing
- Grant latency: `req_i` rises while in IDLE at cycle n; `rd_sel_o` and `busy_o` are valid from cycle n+1.
  - The first `rd_en_o` can occur at cycle n+1.
- Burst with `rd_ready_i` held high and the queue never emptying: `rd_en_o` is high for exactly BURST consecutive cycles, n+1..n+BURST.
  - `rd_sel_o`=0 at n+BURST+1 (the bubble).
  - The next grant is visible at n+BURST+2.
- Throughput with continuous requesters: BURST reads per BURST+1 cycles.
- `rd_en_o` is combinational from the registered state, the registered `rd_sel_o`, `req_i` and `rd_ready_i`. There is no path from `req_i` to `rd_sel_o` within a cycle.
- `grant_idx_o` and `busy_o` are registered.

## Test plan
- **Reset, then single requester.**
  - Stimulus: `req_i`=0010 and `rd_ready_i`=1 held.
  - Required: `rd_sel_o`=0010 and `grant_idx_o`=1 one cycle after reset release; 4 `rd_en_o` pulses; one cycle of `rd_sel_o`=0000; then regrant to 0010.
- **Round-robin fairness.**
  - Stimulus: `req_i`=1111 constant, `rd_ready_i`=1, BURST=4.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001; each grant gives 4 strobes followed by a one-cycle gap.
- **Early empty.**
  - Stimulus: queue 2 is granted, and `req_i[2]` drops after 2 reads.
  - Required: exactly 2 `rd_en_o` pulses; release on the cycle `req_i[2]` is low; the next grant skips to the next requester after index 2.
- **Backpressure.**
  - Stimulus: during the burst of queue 0, `rd_ready_i` is toggled 1,0,0,1,1,0,1.
  - Required: `rd_en_o` mirrors `rd_ready_i`; `cnt` counts only accepted reads; release occurs after the 4th accepted read; `rd_sel_o` is stable throughout.
- **Wrap-around priority.**
  - Stimulus: `last`=3 after serving queue 3, with `req_i`=1001.
  - Required: the next grant is 0001, not 1000.
- **Asynchronous reset mid-burst.**
  - Stimulus: `rst` is pulsed after 2 reads of queue 1.
  - Required: `rd_sel_o`=0, `rd_en_o`=0 and `busy_o`=0 within the same cycle without waiting for a clock edge; after release with `req_i`=0011, the grant goes to queue 0.

Source files
------------

// File: rtl/queue_rd_arbiter.sv
// Round-robin read scheduler for four queues: grants bursts of up to BURST reads,
// releases early when the granted queue empties, and always idles one cycle between grants.
module queue_rd_arbiter #(
  parameter int BURST = 4,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic       rd_ready_i,
  output logic [3:0] rd_sel_o,
  output logic [1:0] grant_idx_o,
  output logic       rd_en_o,
  output logic       busy_o
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      last;
  logic [CW-1:0]   cnt;
  logic [1:0]      winner;
  logic            release_g;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Search starts just past the last-served queue, so it is considered last.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = 2'd0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    release_g = 1'b0;
    case (state)
      IDLE: if (|req_i) state_nxt = SERVE;
      SERVE: begin
        if (!req_i[grant_idx_o] || (rd_en_o && cnt == CW'(BURST - 1))) begin
          release_g = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rd_en_o = (state == SERVE) && rd_ready_i && req_i[grant_idx_o];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last        <= 2'd3;
      cnt         <= '0;
      rd_sel_o    <= 4'b0000;
      grant_idx_o <= 2'd0;
      busy_o      <= 1'b0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (|req_i) begin
        rd_sel_o    <= 4'b0001 << winner;
        grant_idx_o <= winner;
        busy_o      <= 1'b1;
      end
    end else if (release_g) begin
      last        <= grant_idx_o;
      cnt         <= '0;
      rd_sel_o    <= 4'b0000;
      grant_idx_o <= 2'd0;
      busy_o      <= 1'b0;
    end else if (rd_en_o) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_queue_rd_arbiter.sv
// Directed bench for queue_rd_arbiter with BURST=4; inputs change 2ns after the rising edge.
module tb_queue_rd_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req_i = 4'b0000;
  logic       rd_ready_i = 1'b1;
  logic [3:0] rd_sel_o;
  logic [1:0] grant_idx_o;
  logic       rd_en_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  queue_rd_arbiter #(.BURST(4), .CW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .rd_ready_i  (rd_ready_i),
    .rd_sel_o    (rd_sel_o),
    .grant_idx_o (grant_idx_o),
    .rd_en_o     (rd_en_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Expects a full burst of n strobes on es, then the one-cycle bubble.
  task automatic burst(input string tag, input logic [3:0] es, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check({tag, "_sel"}, 32'(rd_sel_o), 32'(es));
      check({tag, "_en"}, 32'(rd_en_o), 32'd1);
      step();
    end
    #1;
    check({tag, "_bubble_sel"}, 32'(rd_sel_o), 32'd0);
    check({tag, "_bubble_en"}, 32'(rd_en_o), 32'd0);
    step();
  endtask

  initial begin
    logic [3:0] seq [5];
    int         pat [7];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    pat = '{1, 0, 0, 1, 1, 0, 1};

    // Reset values, then single requester
    req_i = 4'b0010; rd_ready_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_sel", 32'(rd_sel_o), 32'd0);
    check("rst_idx", 32'(grant_idx_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_en", 32'(rd_en_o), 32'd0);
    rst = 1'b0;
    step();
    #1;
    check("single_idx", 32'(grant_idx_o), 32'd1);
    check("single_busy", 32'(busy_o), 32'd1);
    burst("single", 4'b0010, 4);
    #1;
    check("single_regrant", 32'(rd_sel_o), 32'b0010);

    // Round-robin fairness
    req_i = 4'b1111;
    do_reset();
    step();
    for (int g = 0; g < 5; g++) burst("rr", seq[g], 4);

    // Early empty on queue 2
    req_i = 4'b0100;
    do_reset();
    step();
    #1; check("early_en0", 32'(rd_en_o), 32'd1); step();
    #1; check("early_en1", 32'(rd_en_o), 32'd1); step();
    req_i = 4'b1001;
    #1;
    check("early_sel_hold", 32'(rd_sel_o), 32'b0100);
    check("early_en2", 32'(rd_en_o), 32'd0);
    step();
    #1;
    check("early_release", 32'(rd_sel_o), 32'd0);
    check("early_busy", 32'(busy_o), 32'd0);
    step();
    #1;
    check("early_next", 32'(rd_sel_o), 32'b1000);
    check("early_next_idx", 32'(grant_idx_o), 32'd3);

    // Backpressure on queue 0
    req_i = 4'b0001; rd_ready_i = 1'b1;
    do_reset();
    step();
    for (int i = 0; i < 7; i++) begin
      rd_ready_i = pat[i][0];
      #1;
      check("bp_sel", 32'(rd_sel_o), 32'b0001);
      check("bp_en", 32'(rd_en_o), 32'(pat[i]));
      step();
    end
    rd_ready_i = 1'b1;
    #1;
    check("bp_release", 32'(rd_sel_o), 32'd0);
    check("bp_busy", 32'(busy_o), 32'd0);

    // Wrap-around priority after serving queue 3
    req_i = 4'b1000;
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      #1; check("wrap_q3_en", 32'(rd_en_o), 32'd1); step();
    end
    req_i = 4'b1001;
    #1;
    check("wrap_bubble", 32'(rd_sel_o), 32'd0);
    step();
    #1;
    check("wrap_grant", 32'(rd_sel_o), 32'b0001);

    // Asynchronous reset mid-burst
    req_i = 4'b0010;
    do_reset();
    step();
    #1; check("arst_en0", 32'(rd_en_o), 32'd1); step();
    #1; check("arst_en1", 32'(rd_en_o), 32'd1); step();
    #1; check("arst_pre", 32'(rd_sel_o), 32'b0010);
    rst = 1'b1;
    #1;
    check("arst_sel", 32'(rd_sel_o), 32'd0);
    check("arst_en", 32'(rd_en_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    req_i = 4'b0011;
    rst = 1'b0;
    step();
    #1;
    check("arst_regrant", 32'(rd_sel_o), 32'b0001);
    check("arst_regrant_idx", 32'(grant_idx_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
